// File: rtl/imem_fetch_if.sv
// Bundle of the fetch controller's run control, imem read port and the
// decode-side valid/ready instruction handshake.
interface imem_fetch_if;
    // Handshake: an instruction transfers on a rising edge where inst_valid
    // and inst_ready are both 1. inst_valid, inst and inst_pc are driven only
    // from registered state, so they never depend on inst_ready. Once
    // inst_valid is high, the head entry holds stable until it is popped.
    // A redirect is the one exception: it flushes the queue, so a valid head
    // can be withdrawn without ever being popped.
    logic        run;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        halted;
    logic        fault;
    logic [1:0]  dbg_state;

    modport slave (
        input  run, redirect, redirect_pc, imem_rd, inst_ready,
        output imem_addr, inst_valid, inst, inst_pc, halted, fault, dbg_state
    );

    modport master (
        output run, redirect, redirect_pc, imem_rd, inst_ready,
        input  imem_addr, inst_valid, inst, inst_pc, halted, fault, dbg_state
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads a combinational imem into
// a small prefetch queue and hands instructions to decode via valid/ready.
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MEM_WORDS = 81,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    imem_fetch_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               fault_q, fault_d;
    logic               run_q;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               pop;
    logic               fetch_try;
    logic               in_range;
    logic               push;
    logic [CNT_W-1:0]   count_after_pop;

    // run is registered first, so a HALTED->RUN request costs one extra cycle
    // before the first fetch and the first fetch never races a fresh run edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HALTED;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            run_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            run_q   <= bus.run;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= bus.imem_rd;
            pc_mem[tail_q]   <= pc_q;
        end
    end

    always_comb begin
        pop             = (count_q != '0) && bus.inst_ready;
        in_range        = pc_q[31:2] < 30'(MEM_WORDS);
        fetch_try       = (state_q == ST_RUN) && !fault_q && !bus.redirect &&
                          ((count_q < CNT_W'(DEPTH)) || pop);
        push            = fetch_try && in_range;
        count_after_pop = count_q - CNT_W'(pop);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (bus.redirect) begin
            // Flush wins over everything, including a same-cycle pop.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
            fault_d = 1'b0;
            if (state_q == ST_DRAIN) begin
                state_d = ST_HALTED;
            end
        end else begin
            if (fetch_try && !in_range) begin
                fault_d = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_after_pop + CNT_W'(push);

            case (state_q)
                ST_HALTED: begin
                    if (run_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (run_q) begin
                        state_d = ST_RUN;
                    end else if (count_after_pop == '0) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase
        end
    end

    always_comb begin
        bus.imem_addr  = pc_q;
        bus.inst_valid = (count_q != '0);
        bus.inst       = bus.inst_valid ? inst_mem[head_q] : 32'h0;
        bus.inst_pc    = bus.inst_valid ? pc_mem[head_q]   : 32'h0;
        bus.halted     = (state_q == ST_HALTED);
        bus.fault      = fault_q;
        bus.dbg_state  = state_q;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: stream, stall, redirect, fault, drain
// and asynchronous reset sequences against hand-derived expectations.
module tb_imem_fetch_ctrl;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];

  imem_fetch_if bus();

  imem_fetch_ctrl #(
    .DEPTH(2),
    .MEM_WORDS(81),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: word i holds 0xC0DE0000 + i.
  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    return 32'hC0DE_0000 + {2'b00, idx};
  endfunction

  always_comb begin
    if (bus.imem_addr[31:2] < 30'd81) bus.imem_rd = mem_word(bus.imem_addr[31:2]);
    else bus.imem_rd = 32'hBAD0_BAD0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
    check_eq({tag, "_pc"}, bus.inst_pc, pc);
    check_eq({tag, "_inst"}, bus.inst, mem_word(pc[31:2]));
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    check_eq({tag, "_inst"}, bus.inst, 32'd0);
    check_eq({tag, "_pc"}, bus.inst_pc, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.run = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;

    // Reset values
    #1;
    check_empty("rst");
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_halted", {31'd0, bus.halted}, 32'd1);
    check_eq("rst_fault", {31'd0, bus.fault}, 32'd0);
    #11 reset = 1'b1;
    tick();
    check_eq("idle_halted", {31'd0, bus.halted}, 32'd1);

    // Streaming from reset: run sampled, RUN next edge, first push the edge after
    bus.run = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    check_eq("run_sampled_halted", {31'd0, bus.halted}, 32'd1);
    tick();
    check_eq("run_halted_fall", {31'd0, bus.halted}, 32'd0);
    check_eq("run_no_valid_yet", {31'd0, bus.inst_valid}, 32'd0);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e;
      tick();
      e = exp_q.pop_front();
      check_head("stream", e);
    end

    // Stall with head at 0x10
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_head("stall", 32'h10);
      check_eq("stall_addr", bus.imem_addr, 32'h18);
    end
    bus.inst_ready = 1'b1;
    tick();
    check_head("release0", 32'h14);
    tick();
    check_head("release1", 32'h18);
    tick();
    check_head("release2", 32'h1C);
    tick();
    check_head("pre_redir", 32'h20);

    // Redirect while popping 0x20, unaligned target
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h43;
    tick();
    check_empty("redir_bubble");
    check_eq("redir_addr", bus.imem_addr, 32'h40);
    bus.redirect = 1'b0;
    tick();
    check_head("redir_target", 32'h40);

    // Last valid word then out-of-range fault
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h140;
    tick();
    check_eq("lastw_addr", bus.imem_addr, 32'h140);
    bus.redirect = 1'b0;
    tick();
    check_head("lastw", 32'h140);
    check_eq("lastw_fault", {31'd0, bus.fault}, 32'd0);
    tick();
    check_empty("fault0");
    check_eq("fault0_flag", {31'd0, bus.fault}, 32'd1);
    check_eq("fault0_addr", bus.imem_addr, 32'h144);
    tick();
    check_eq("fault1_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("fault1_flag", {31'd0, bus.fault}, 32'd1);
    check_eq("fault1_addr", bus.imem_addr, 32'h144);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    check_eq("fault_clr", {31'd0, bus.fault}, 32'd0);
    check_eq("fault_clr_addr", bus.imem_addr, 32'h0);
    bus.redirect = 1'b0;
    tick();
    check_head("after_fault", 32'h0);

    // Drain with two entries queued and decode stalled
    bus.inst_ready = 1'b0;
    tick();
    check_eq("fill_addr", bus.imem_addr, 32'h8);
    bus.run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_head("drain_hold", 32'h0);
      check_eq("drain_halted", {31'd0, bus.halted}, 32'd0);
      check_eq("drain_addr", bus.imem_addr, 32'h8);
    end
    check_eq("drain_state", {30'd0, bus.dbg_state}, 32'd2);
    bus.inst_ready = 1'b1;
    tick();
    check_head("drain_pop0", 32'h4);
    check_eq("drain_pop0_halted", {31'd0, bus.halted}, 32'd0);
    tick();
    check_empty("drain_empty");
    check_eq("drain_done_halted", {31'd0, bus.halted}, 32'd1);
    check_eq("drain_done_addr", bus.imem_addr, 32'h8);
    tick();
    check_eq("halt_hold_addr", bus.imem_addr, 32'h8);
    check_eq("halt_hold", {31'd0, bus.halted}, 32'd1);

    // Asynchronous reset with two entries queued
    bus.run = 1'b1;
    bus.inst_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check_head("pre_reset", 32'h8);
    check_eq("pre_reset_addr", bus.imem_addr, 32'h10);
    #2 reset = 1'b0;
    #1;
    check_empty("async_rst");
    check_eq("async_rst_addr", bus.imem_addr, 32'h0);
    check_eq("async_rst_halted", {31'd0, bus.halted}, 32'd1);
    #5 reset = 1'b1;
    bus.run = 1'b0;
    tick();
    check_eq("post_rst_halted", {31'd0, bus.halted}, 32'd1);
    check_eq("post_rst_valid", {31'd0, bus.inst_valid}, 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
